// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-ported register file.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package RegfileMpPkg;

    // Default architectural register entry.
    typedef logic [31:0] entry_t;

    // Architectural register that always reads zero.
    localparam int ZERO_REG = 0;

    // Address width for a register count; never narrower than one bit.
    function automatic int addr_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set on allocation, cleared on writeback.
// Latency: updates at the clock edge; the pend vector reflects the stored state.
// Backpressure: none; every alloc and write is accepted each cycle.
module regfile_mp_scoreboard
    import RegfileMpPkg::*;
#(
    parameter  int p_num_regs   = 32,
    parameter  int p_num_wports = 2,
    localparam int p_addr_bits  = addr_bits(p_num_regs)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_en_i,
    input  logic [p_addr_bits-1:0] alloc_addr_i,
    input  logic                   wen_i   [p_num_wports],
    input  logic [p_addr_bits-1:0] waddr_i [p_num_wports],
    output logic [p_num_regs-1:0]  pend_o
);

    logic [p_num_regs-1:0] pend_q;
    logic [p_num_regs-1:0] pend_d;
    logic [p_num_regs-1:0] set_vec;
    logic [p_num_regs-1:0] clr_vec;
    logic [p_num_regs-1:0] next_vec;

    // Decode the allocation and every writeback lane into one-hot set/clear masks.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (alloc_en_i) begin
            set_vec[alloc_addr_i] = 1'b1;
        end
        for (int j = 0; j < p_num_wports; j++) begin
            if (wen_i[j]) begin
                clr_vec[waddr_i[j]] = 1'b1;
            end
        end
    end

    // Set wins over clear: the newest producer owns the register. Bit 0 never goes pending.
    assign next_vec = (pend_q & ~clr_vec) | set_vec;
    assign pend_d   = {next_vec[p_num_regs-1:1], 1'b0};

    // Pending state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register pending bits; optional forwarding via REGFILE_MP_BYPASS_EN.
// Latency: reads combinational (zero cycles); writes visible the cycle after the edge.
// Backpressure: none; all ports are serviced every cycle, highest write port wins on collisions.
module regfile_mp
    import RegfileMpPkg::*;
#(
    parameter  type t_entry      = entry_t,
    parameter  int  p_num_regs   = 32,
    parameter  int  p_num_rports = 2,
    parameter  int  p_num_wports = 2,
    localparam int  p_addr_bits  = addr_bits(p_num_regs)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [p_addr_bits-1:0] raddr [p_num_rports],
    output t_entry                 rdata [p_num_rports],
    output logic                   rpend [p_num_rports],
    input  logic [p_addr_bits-1:0] waddr [p_num_wports],
    input  t_entry                 wdata [p_num_wports],
    input  logic                   wen   [p_num_wports],
    input  logic                   alloc_en,
    input  logic [p_addr_bits-1:0] alloc_addr
);

    localparam logic [p_addr_bits-1:0] ZERO_ADDR = p_addr_bits'(ZERO_REG);

    t_entry                regs_q [p_num_regs];
    t_entry                regs_d [p_num_regs];
    logic [p_num_regs-1:0] pend;

    regfile_mp_scoreboard #(
        .p_num_regs   (p_num_regs),
        .p_num_wports (p_num_wports)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .alloc_en_i   (alloc_en),
        .alloc_addr_i (alloc_addr),
        .wen_i        (wen),
        .waddr_i      (waddr),
        .pend_o       (pend)
    );

    // Apply write lanes in ascending order so the highest-index lane wins a shared address.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < p_num_wports; j++) begin
            if (wen[j] && (waddr[j] != ZERO_ADDR)) begin
                regs_d[waddr[j]] = wdata[j];
            end
        end
    end

    // Register storage, cleared asynchronously; entry 0 is never written and stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < p_num_regs; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes: stored value and pending bit, with register 0 forced to zero.
    always_comb begin
        for (int i = 0; i < p_num_rports; i++) begin
            rdata[i] = regs_q[raddr[i]];
            rpend[i] = pend[raddr[i]];
            if (raddr[i] == ZERO_ADDR) begin
                rdata[i] = '0;
                rpend[i] = 1'b0;
            end
`ifdef REGFILE_MP_BYPASS_EN
            // Forward in-flight writeback data; reset keeps outputs at zero.
            if (rst && (raddr[i] != ZERO_ADDR)) begin
                for (int j = 0; j < p_num_wports; j++) begin
                    if (wen[j] && (waddr[j] == raddr[i])) begin
                        rdata[i] = wdata[j];
                        rpend[i] = alloc_en && (alloc_addr == raddr[i]);
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  raddr [2];
    logic [31:0] rdata [2];
    logic        rpend [2];
    logic [4:0]  waddr [2];
    logic [31:0] wdata [2];
    logic        wen   [2];
    logic        alloc_en;
    logic [4:0]  alloc_addr;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mreg  [32];
    logic        mpend [32];

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk        (clk),
        .rst        (rst),
        .raddr      (raddr),
        .rdata      (rdata),
        .rpend      (rpend),
        .waddr      (waddr),
        .wdata      (wdata),
        .wen        (wen),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wen[0]   = 1'b0;
        wen[1]   = 1'b0;
        alloc_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr[0] = a0;
        raddr[1] = a1;
        #1;
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        wen[port]   = 1'b1;
        waddr[port] = a;
        wdata[port] = d;
    endtask

    task automatic alloc(input logic [4:0] a);
        alloc_en   = 1'b1;
        alloc_addr = a;
    endtask

    initial begin
        logic [31:0] exp_d;
        logic        exp_p;

        rst = 1'b0;
        idle();
        alloc_addr = '0;
        for (int p = 0; p < 2; p++) begin
            raddr[p] = '0;
            waddr[p] = '0;
            wdata[p] = '0;
        end

        // Reset state
        rd(5'd5, 5'd5);
        check("rst_rdata0", rdata[0], 32'h0);
        check("rst_rdata1", rdata[1], 32'h0);
        check("rst_rpend0", 32'(rpend[0]), 32'h0);
        check("rst_rpend1", 32'(rpend[1]), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single write, two ports reading the same register
        wr(0, 5'd3, 32'h0000_abcd);
        tick();
        idle();
        rd(5'd3, 5'd3);
        check("wr3_port0", rdata[0], 32'h0000_abcd);
        check("wr3_port1", rdata[1], 32'h0000_abcd);

        // Dual write to reg 7: port 1 wins
        wr(0, 5'd7, 32'h0000_1111);
        wr(1, 5'd7, 32'h0000_2222);
        tick();
        idle();
        rd(5'd7, 5'd3);
        check("dual_wr7", rdata[0], 32'h0000_2222);
        check("dual_keep3", rdata[1], 32'h0000_abcd);

        // Register 0: write and alloc both ignored
        wr(0, 5'd0, 32'h0000_baad);
        alloc(5'd0);
        tick();
        idle();
        rd(5'd0, 5'd0);
        check("r0_rdata", rdata[0], 32'h0);
        check("r0_rpend", 32'(rpend[0]), 32'h0);

        // Scoreboard: alloc, write clears, alloc beats clear
        alloc(5'd6);
        tick();
        idle();
        rd(5'd6, 5'd7);
        check("sb_alloc_pend", 32'(rpend[0]), 32'h1);
        check("sb_other_pend", 32'(rpend[1]), 32'h0);
        wr(1, 5'd6, 32'h0000_1234);
        tick();
        idle();
        rd(5'd6, 5'd6);
        check("sb_clr_pend", 32'(rpend[0]), 32'h0);
        check("sb_clr_data", rdata[0], 32'h0000_1234);
        wr(0, 5'd6, 32'h0000_4321);
        alloc(5'd6);
        tick();
        idle();
        rd(5'd6, 5'd6);
        check("sb_both_pend", 32'(rpend[1]), 32'h1);
        check("sb_both_data", rdata[1], 32'h0000_4321);

        // Same-cycle write and read of reg 9 (pending beforehand)
        alloc(5'd9);
        tick();
        idle();
        wr(0, 5'd9, 32'h0000_5678);
        rd(5'd9, 5'd9);
`ifdef REGFILE_MP_BYPASS_EN
        check("byp_rdata", rdata[0], 32'h0000_5678);
        check("byp_rpend", 32'(rpend[0]), 32'h0);
`else
        check("nobyp_rdata", rdata[0], 32'h0);
        check("nobyp_rpend", 32'(rpend[0]), 32'h1);
`endif
        tick();
        idle();
        rd(5'd9, 5'd9);
        check("r9_after_data", rdata[1], 32'h0000_5678);
        check("r9_after_pend", 32'(rpend[1]), 32'h0);

        // Mid-test asynchronous reset
        wr(0, 5'd5, 32'h0000_f00d);
        tick();
        idle();
        alloc(5'd5);
        tick();
        idle();
        rd(5'd5, 5'd3);
        check("pre_rst_data", rdata[0], 32'h0000_f00d);
        check("pre_rst_pend", 32'(rpend[0]), 32'h1);
        rst = 1'b0;
        #1;
        check("async_rst_data", rdata[0], 32'h0);
        check("async_rst_pend", 32'(rpend[0]), 32'h0);
        check("async_rst_r3", rdata[1], 32'h0);
        wr(1, 5'd5, 32'h0000_0001);
        alloc(5'd5);
        tick();
        idle();
        rd(5'd5, 5'd5);
        check("rst_hold_data", rdata[0], 32'h0);
        check("rst_hold_pend", 32'(rpend[0]), 32'h0);
        rst = 1'b1;
        tick();

        // Random traffic against a reference model (state is all-zero after reset)
        for (int r = 0; r < 32; r++) begin
            mreg[r]  = '0;
            mpend[r] = 1'b0;
        end
        for (int c = 0; c < 20; c++) begin
            for (int p = 0; p < 2; p++) begin
                raddr[p] = 5'($urandom_range(0, 7));
                waddr[p] = 5'($urandom_range(0, 7));
                wdata[p] = $urandom;
                wen[p]   = 1'($urandom_range(0, 1));
            end
            alloc_en   = 1'($urandom_range(0, 1));
            alloc_addr = 5'($urandom_range(0, 7));
            #1;
            for (int i = 0; i < 2; i++) begin
                exp_d = (raddr[i] == 5'd0) ? 32'h0 : mreg[raddr[i]];
                exp_p = (raddr[i] == 5'd0) ? 1'b0 : mpend[raddr[i]];
`ifdef REGFILE_MP_BYPASS_EN
                for (int j = 0; j < 2; j++) begin
                    if (wen[j] && waddr[j] == raddr[i] && raddr[i] != 5'd0) begin
                        exp_d = wdata[j];
                        exp_p = alloc_en && (alloc_addr == raddr[i]);
                    end
                end
`endif
                check($sformatf("rand%0d_rdata%0d", c, i), rdata[i], exp_d);
                check($sformatf("rand%0d_rpend%0d", c, i), 32'(rpend[i]), 32'(exp_p));
            end
            tick();
            for (int r = 1; r < 32; r++) begin
                logic hit;
                hit = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    if (wen[j] && waddr[j] == 5'(r)) begin
                        mreg[r] = wdata[j];
                        hit     = 1'b1;
                    end
                end
                if (alloc_en && alloc_addr == 5'(r)) begin
                    mpend[r] = 1'b1;
                end else if (hit) begin
                    mpend[r] = 1'b0;
                end
            end
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
